// File: rtl/axil_lsu_pkg.sv
// Shared types and constants for the AXI-Lite load/store master.
package axil_lsu_pkg;

    // CPU access size; encoding 3 is not a member and is always rejected as misaligned.
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } lsu_size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR_DATA,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_ERR
    } lsu_state_t;

    localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

    // Bit of bresp/rresp that marks SLVERR/DECERR.
    localparam int RESP_SLVERR = 1;

endpackage

// File: rtl/axil_lsu_if.sv
// AXI-Lite bus bundle (32-bit address, 32-bit data) with master/slave views.
interface axil_lsu_if;

    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for a 32-bit bus: store strobes and replicated write data,
// load lane extraction with sign/zero extension, and alignment check.
module lsu_lane_align
    import axil_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  a_lo,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [31:0] lane;

    assign lane = rdata >> {a_lo, 3'b000};

    // Per-size strobe, replication and extension
    always_comb begin
        misaligned = 1'b0;
        wstrb      = 4'h0;
        wdata_rep  = wdata;
        rdata_ext  = lane;
        case (size)
            SIZE_B: begin
                wstrb     = 4'b0001 << a_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sgn & lane[7]}}, lane[7:0]};
            end
            SIZE_H: begin
                misaligned = a_lo[0];
                wstrb      = 4'b0011 << a_lo;
                wdata_rep  = {2{wdata[15:0]}};
                rdata_ext  = {{16{sgn & lane[15]}}, lane[15:0]};
            end
            SIZE_W: begin
                misaligned = (a_lo != 2'b00);
                wstrb      = 4'hF;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/axil_lsu_master.sv
// CPU load/store to single-beat AXI-Lite master, one transaction in flight.
// Optional watchdog: define AXIL_LSU_TIMEOUT_EN to abort a stuck transaction
// after TIMEOUT_CYCLES and drain late B/R beats while idle.
//
// state           | meaning
// ST_IDLE         | req_ready high (except in the rsp_valid cycle), waiting for a request
// ST_WR_ADDR_DATA | awvalid/wvalid outstanding, each drops on its own handshake
// ST_WR_RESP      | bready high, waiting for bvalid
// ST_RD_ADDR      | arvalid outstanding
// ST_RD_DATA      | rready high, waiting for rvalid
// ST_ERR          | misaligned request, error response without bus activity
module axil_lsu_master
    import axil_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    axil_lsu_if.master            m_axil
);

`ifdef AXIL_LSU_TIMEOUT_EN
    localparam bit IDLE_DRAIN = 1'b1;
    logic [31:0] tmr_q, tmr_d;
`else
    localparam bit IDLE_DRAIN = 1'b0;
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    lsu_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;
    logic                  rready_q, rready_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;

    logic                  la_idle;
    logic [1:0]            la_size;
    logic [1:0]            la_alo;
    logic [3:0]            la_wstrb;
    logic [31:0]           la_wdata;
    logic [31:0]           la_rdata;
    logic                  la_misaligned;
    logic                  unused_resp;

    // In IDLE the aligner looks at the incoming request (strobes, misalignment);
    // afterwards it looks at the latched request to extract the load lane.
    assign la_idle = (state_q == ST_IDLE);
    assign la_size = la_idle ? req_size : size_q;
    assign la_alo  = la_idle ? req_addr[1:0] : addr_q[1:0];

    lsu_lane_align u_align (
        .size       (la_size),
        .a_lo       (la_alo),
        .sgn        (signed_q),
        .wdata      (req_wdata),
        .rdata      (m_axil.rdata),
        .wstrb      (la_wstrb),
        .wdata_rep  (la_wdata),
        .rdata_ext  (la_rdata),
        .misaligned (la_misaligned)
    );

    // Next-state and next-output logic; every output is a flop
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        signed_d    = signed_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
`ifdef AXIL_LSU_TIMEOUT_EN
        tmr_d       = tmr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d   = req_addr;
                    size_d   = req_size;
                    signed_d = req_signed;
                    wstrb_d  = la_wstrb;
                    wdata_d  = la_wdata;
`ifdef AXIL_LSU_TIMEOUT_EN
                    tmr_d    = 32'(TIMEOUT_CYCLES - 1);
`endif
                    if (la_misaligned) begin
                        state_d = ST_ERR;
                    end else if (req_write) begin
                        state_d   = ST_WR_ADDR_DATA;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_ERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_WR_ADDR_DATA: begin
                if (awvalid_q && m_axil.awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axil.wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d)     state_d   = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (m_axil.bvalid) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = m_axil.bresp[RESP_SLVERR];
                    state_d     = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (m_axil.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_axil.rvalid) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = m_axil.rresp[RESP_SLVERR];
                    rsp_rdata_d = m_axil.rresp[RESP_SLVERR] ? 32'h0 : la_rdata;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef AXIL_LSU_TIMEOUT_EN
        // Watchdog abort overrides any handshake in the same cycle; it
        // deliberately drops valids without a handshake.
        if (state_q inside {ST_WR_ADDR_DATA, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA}) begin
            if (tmr_q == 32'd0) begin
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                arvalid_d   = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
                state_d     = ST_IDLE;
            end else begin
                tmr_d = tmr_q - 32'd1;
            end
        end
`endif
        bready_d    = (state_d == ST_WR_RESP) || (IDLE_DRAIN && state_d == ST_IDLE);
        rready_d    = (state_d == ST_RD_DATA) || (IDLE_DRAIN && state_d == ST_IDLE);
        // Hold req_ready low for the response cycle so it returns one cycle later.
        req_ready_d = (state_d == ST_IDLE) && !rsp_valid_d;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            size_q      <= 2'd0;
            signed_q    <= 1'b0;
            wstrb_q     <= 4'h0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef AXIL_LSU_TIMEOUT_EN
            tmr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef AXIL_LSU_TIMEOUT_EN
            tmr_q       <= tmr_d;
`endif
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_rdata      = rsp_rdata_q;

    assign m_axil.awaddr  = {addr_q[31:2], 2'b00};
    assign m_axil.araddr  = {addr_q[31:2], 2'b00};
    assign m_axil.awprot  = AXIL_PROT_DEFAULT;
    assign m_axil.arprot  = AXIL_PROT_DEFAULT;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = wstrb_q;
    assign m_axil.bready  = bready_q;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.rready  = rready_q;

    // Only the error bit of each response matters.
    assign unused_resp = ^{m_axil.bresp[0], m_axil.rresp[0]};

endmodule
